// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner with config handshake, match counter and auto-stop.
// Ports: clk/rst (async active-low); cfg_* config offer (cfg_ready in IDLE);
//        start/stop scan control; x_valid/x serial input;
//        busy/done state flags, match pulse, match_cnt, err pulse.
module pattern_scan_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             start,
    input  logic             stop,
    input  logic             x_valid,
    input  logic             x,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic             cfg_ok, cfg_ok_nx;
    logic [7:0]       pattern, pattern_nx;
    logic [3:0]       len, len_nx;
    logic             overlap, overlap_nx;
    logic [CNT_W-1:0] limit, limit_nx;
    logic [7:0]       history, history_nx;
    logic [3:0]       bcnt, bcnt_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             match_nx;
    logic             err_nx;

    logic [7:0]       hist_sh;
    logic [3:0]       bcnt_inc;
    logic [7:0]       mask;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit;
    logic             len_legal;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign cfg_ready = (state == IDLE);
    assign busy      = (state == SCAN);
    assign done      = (state == DONE);

    // Candidate values as if the current bit were shifted in.
    assign hist_sh   = {history[6:0], x};
    assign bcnt_inc  = (bcnt == 4'd8) ? 4'd8 : bcnt + 4'd1;
    // len is 1..8 whenever SCAN is reachable, so the shift is 0..7.
    assign mask      = 8'hFF >> (4'd8 - len);
    assign cnt_inc   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_ONE;
    assign len_legal = (cfg_len != 4'd0) && (cfg_len <= 4'd8);

    assign hit = (state == SCAN) && x_valid
              && (bcnt_inc >= len)
              && ((hist_sh & mask) == (pattern & mask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cfg_ok    <= 1'b0;
            pattern   <= '0;
            len       <= '0;
            overlap   <= 1'b0;
            limit     <= '0;
            history   <= '0;
            bcnt      <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_ok    <= cfg_ok_nx;
            pattern   <= pattern_nx;
            len       <= len_nx;
            overlap   <= overlap_nx;
            limit     <= limit_nx;
            history   <= history_nx;
            bcnt      <= bcnt_nx;
            match_cnt <= cnt_nx;
            match     <= match_nx;
            err       <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cfg_ok_nx  = cfg_ok;
        pattern_nx = pattern;
        len_nx     = len;
        overlap_nx = overlap;
        limit_nx   = limit;
        history_nx = history;
        bcnt_nx    = bcnt;
        cnt_nx     = match_cnt;
        match_nx   = 1'b0;
        err_nx     = 1'b0;

        case (state)
            IDLE, DONE: begin
                // A config offer wins over a start in the same cycle.
                if (cfg_valid) begin
                    if (len_legal) begin
                        pattern_nx = cfg_pattern;
                        len_nx     = cfg_len;
                        overlap_nx = cfg_overlap;
                        limit_nx   = cfg_limit;
                        cfg_ok_nx  = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (start) begin
                    if (cfg_ok) begin
                        history_nx = '0;
                        bcnt_nx    = '0;
                        cnt_nx     = '0;
                        state_nx   = SCAN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (x_valid) begin
                    history_nx = hist_sh;
                    // Non-overlapping mode restarts the length window.
                    bcnt_nx = (hit && !overlap) ? 4'd0 : bcnt_inc;
                end
                if (hit) begin
                    match_nx = 1'b1;
                    cnt_nx   = cnt_inc;
                    if ((limit != '0) && (cnt_inc == limit))
                        state_nx = DONE;
                end
                // Abort takes precedence over reaching the limit.
                if (stop)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed testbench for pattern_scan_ctrl.
// Scenario tasks drive stimulus and compare against hand-computed values.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_limit = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       x_valid = 1'b0;
    logic       x = 1'b0;
    logic       busy;
    logic       match;
    logic [7:0] match_cnt;
    logic       done;
    logic       err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] hits;

    pattern_scan_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_limit(cfg_limit),
        .start(start), .stop(stop),
        .x_valid(x_valid), .x(x),
        .busy(busy), .match(match), .match_cnt(match_cnt),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [7:0] p, input logic [3:0] l,
                             input logic ov, input logic [7:0] lim);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        cfg_limit   = lim;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Sends 8 bits MSB first, recording which bit produced a match pulse.
    task automatic send_byte(input logic [7:0] b);
        hits = '0;
        for (int i = 0; i < 8; i++) begin
            x_valid = 1'b1;
            x = b[7-i];
            tick();
            hits[i] = match;
        end
        x_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        x_valid = 1'b1;
        x = b;
        tick();
        x_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        vectors++;
        if ({cfg_ready, busy, done, match, err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b exp=10000",
                     {cfg_ready, busy, done, match, err});
        end
        vectors++;
        if (match_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got=%0d exp=0", match_cnt);
        end
        #10 rst = 1'b1;
        tick();
    endtask

    task automatic test_start_noconfig();
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({err, cfg_ready, busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL start_nocfg got=%b exp=110",
                     {err, cfg_ready, busy});
        end
        tick();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse_len got=%b exp=0", err);
        end
    endtask

    task automatic test_bad_len();
        configure(8'h0A, 4'd4, 1'b0, 8'd0);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_good_err got=%b exp=0", err);
        end
        configure(8'hFF, 4'd0, 1'b1, 8'd1);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_len0_err got=%b exp=1", err);
        end
        configure(8'hFF, 4'd9, 1'b1, 8'd1);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_len9_err got=%b exp=1", err);
        end
        // cfg_valid beats start in the same cycle
        cfg_valid = 1'b1;
        cfg_pattern = 8'h0A;
        cfg_len = 4'd4;
        cfg_overlap = 1'b0;
        cfg_limit = 8'd0;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        vectors++;
        if ({busy, cfg_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL cfg_over_start got=%b exp=01", {busy, cfg_ready});
        end
        configure(8'h00, 4'd9, 1'b0, 8'd0);
        do_start();
        vectors++;
        if ({busy, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL start_after_bad got=%b exp=10", {busy, err});
        end
        // old config 1010 must still be in force
        send_byte(8'b1010_0000);
        vectors++;
        if (hits !== 8'b0000_1000) begin
            miscompares++;
            $display("FAIL kept_cfg hits=%b exp=00001000", hits);
        end
        do_stop();
    endtask

    task automatic test_nonoverlap();
        configure(8'h0A, 4'd4, 1'b0, 8'd0);
        do_start();
        vectors++;
        if (match_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL start_clear got=%0d exp=0", match_cnt);
        end
        send_byte(8'b1010_1010);
        vectors++;
        if (hits !== 8'b1000_1000) begin
            miscompares++;
            $display("FAIL nonovl_hits got=%b exp=10001000", hits);
        end
        vectors++;
        if ({match_cnt, busy} !== {8'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL nonovl_cnt got=%0d busy=%b exp=2 busy=1",
                     match_cnt, busy);
        end
        do_stop();
    endtask

    task automatic test_overlap();
        configure(8'h0A, 4'd4, 1'b1, 8'd0);
        do_start();
        send_byte(8'b1010_1010);
        vectors++;
        if (hits !== 8'b1010_1000) begin
            miscompares++;
            $display("FAIL ovl_hits got=%b exp=10101000", hits);
        end
        vectors++;
        if (match_cnt !== 8'd3) begin
            miscompares++;
            $display("FAIL ovl_cnt got=%0d exp=3", match_cnt);
        end
        do_stop();
        vectors++;
        if ({cfg_ready, match_cnt} !== {1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL stop_keep got=%b/%0d exp=1/3",
                     cfg_ready, match_cnt);
        end
    endtask

    task automatic test_limit();
        configure(8'h0A, 4'd4, 1'b1, 8'd2);
        do_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        vectors++;
        if ({match, done, busy, match_cnt} !== {3'b110, 8'd2}) begin
            miscompares++;
            $display("FAIL limit_hit got=%b%b%b/%0d exp=110/2",
                     match, done, busy, match_cnt);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        vectors++;
        if ({match, done, match_cnt} !== {2'b01, 8'd2}) begin
            miscompares++;
            $display("FAIL limit_hold got=%b%b/%0d exp=01/2",
                     match, done, match_cnt);
        end
    endtask

    task automatic test_gaps();
        configure(8'h0A, 4'd4, 1'b0, 8'd0);
        do_start();
        send_bit(1'b1);
        tick();
        send_bit(1'b0);
        tick();
        tick();
        send_bit(1'b1);
        vectors++;
        if (match !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_early got=%b exp=0", match);
        end
        send_bit(1'b0);
        vectors++;
        if ({match, match_cnt} !== {1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL gap_hit got=%b/%0d exp=1/1", match, match_cnt);
        end
        tick();
        vectors++;
        if (match !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_pulse_len got=%b exp=0", match);
        end
    endtask

    task automatic test_stop_start();
        stop = 1'b1;
        start = 1'b1;
        tick();
        stop = 1'b0;
        start = 1'b0;
        vectors++;
        if ({cfg_ready, busy, err, match_cnt} !== {3'b100, 8'd1}) begin
            miscompares++;
            $display("FAIL stop_start got=%b%b%b/%0d exp=100/1",
                     cfg_ready, busy, err, match_cnt);
        end
    endtask

    task automatic test_stop_on_hit();
        configure(8'h05, 4'd3, 1'b0, 8'd0);
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        x_valid = 1'b1;
        x = 1'b1;
        stop = 1'b1;
        tick();
        x_valid = 1'b0;
        stop = 1'b0;
        vectors++;
        if ({match, cfg_ready, busy, match_cnt} !== {3'b110, 8'd1}) begin
            miscompares++;
            $display("FAIL stop_hit got=%b%b%b/%0d exp=110/1",
                     match, cfg_ready, busy, match_cnt);
        end
    endtask

    task automatic test_reset_mid();
        configure(8'h0A, 4'd4, 1'b0, 8'd0);
        do_start();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({cfg_ready, busy, match_cnt} !== {2'b10, 8'd0}) begin
            miscompares++;
            $display("FAIL mid_rst got=%b%b/%0d exp=10/0",
                     cfg_ready, busy, match_cnt);
        end
        #10 rst = 1'b1;
        tick();
        configure(8'h0A, 4'd4, 1'b0, 8'd0);
        do_start();
        send_bit(1'b0);
        vectors++;
        if ({match, match_cnt} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL post_rst got=%b/%0d exp=0/0", match, match_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_start_noconfig();
        test_bad_len();
        test_nonoverlap();
        test_overlap();
        test_limit();
        test_gaps();
        test_stop_start();
        test_stop_on_hit();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
